// File: rtl/plab4_net_router_input_wormhole_ctrl.sv
// Input-terminal wormhole controller for a ring router port: routes head flits
// greedily around the ring, then locks the chosen output for the packet body.
module plab4_net_router_input_wormhole_ctrl #(
  parameter int p_router_id      = 0,
  parameter int p_num_routers    = 8,
  parameter int p_num_free_nbits = 2,
  parameter int p_len_nbits      = 4,
  parameter int p_bubble_en      = 1,
  localparam int c_dest_nbits    = $clog2(p_num_routers)
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [c_dest_nbits-1:0]     dest,
  input  logic [p_len_nbits-1:0]      len,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [p_num_free_nbits-1:0] num_free_west,
  input  logic [p_num_free_nbits-1:0] num_free_east,
  output logic [2:0]                  reqs,
  input  logic [2:0]                  grants,
  output logic                        busy,
  output logic [p_len_nbits-1:0]      flits_left
);

  // state   | meaning
  // ST_HEAD | next flit is a head; route from dest, bubble rule on ring ports
  // ST_BODY | body flits remain; requests go to the locked port only
  typedef enum logic {ST_HEAD, ST_BODY} state_t;

  state_t                 state, state_next;
  logic [2:0]             lock, lock_next;
  logic [p_len_nbits-1:0] flits_next;
  logic [2:0]             reqs_c;
  logic                   xfer;

  logic [31:0] fwd;
  logic        route_term, route_next;
  logic [2:0]  head_port;
  logic        west_head_ok, east_head_ok, west_ok, east_ok;

  assign fwd = (32'(dest) + 32'(p_num_routers) - 32'(p_router_id)) % 32'(p_num_routers);

  // Ties (fwd == N/2) go NEXT.
  assign route_term = (fwd == 32'd0);
  assign route_next = !route_term && (fwd <= (32'(p_num_routers) - fwd));
  assign head_port  = route_term ? 3'b010 : (route_next ? 3'b100 : 3'b001);

  assign west_ok = (num_free_west != '0);
  assign east_ok = (num_free_east != '0);
  // Bubble rule keeps one slot free on the ring so injection cannot deadlock it.
  assign west_head_ok = (p_bubble_en != 0) ? ((num_free_west >> 1) != '0) : west_ok;
  assign east_head_ok = (p_bubble_en != 0) ? ((num_free_east >> 1) != '0) : east_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_HEAD;
      lock       <= 3'b000;
      flits_left <= '0;
    end else begin
      state      <= state_next;
      lock       <= lock_next;
      flits_left <= flits_next;
    end
  end

  always_comb begin
    state_next = state;
    lock_next  = lock;
    flits_next = flits_left;
    reqs_c     = 3'b000;
    xfer       = 1'b0;

    case (state)
      ST_HEAD: begin
        if (in_val) begin
          if (route_term)
            reqs_c = 3'b010;
          else if (route_next && west_head_ok)
            reqs_c = 3'b100;
          else if (!route_next && east_head_ok)
            reqs_c = 3'b001;
        end
      end
      ST_BODY: begin
        if (in_val && (lock[1] || (lock[2] && west_ok) || (lock[0] && east_ok)))
          reqs_c = lock;
      end
      default: reqs_c = 3'b000;
    endcase

    if (reset)
      reqs_c = 3'b000;

    xfer = |(reqs_c & grants);

    if (xfer) begin
      if (state == ST_HEAD) begin
        if (len != '0) begin
          state_next = ST_BODY;
          lock_next  = head_port;
          flits_next = len;
        end
      end else begin
        flits_next = flits_left - p_len_nbits'(1);
        if (flits_left == p_len_nbits'(1)) begin
          state_next = ST_HEAD;
          lock_next  = 3'b000;
        end
      end
    end
  end

  assign reqs   = reqs_c;
  assign in_rdy = xfer;
  assign busy   = (state == ST_BODY);

endmodule

// File: tb/tb_plab4_net_router_input_wormhole_ctrl.sv
// Directed bench for the wormhole input controller: N=8, id=2, with a second
// instance that has the bubble rule disabled.
module tb_plab4_net_router_input_wormhole_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dest;
  logic [3:0] len;
  logic       in_val;
  logic [1:0] num_free_west, num_free_east;
  logic [2:0] grants;

  logic       in_rdy, busy;
  logic [2:0] reqs;
  logic [3:0] flits_left;
  logic       nb_in_rdy, nb_busy;
  logic [2:0] nb_reqs;
  logic [3:0] nb_flits_left;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  plab4_net_router_input_wormhole_ctrl #(
    .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2),
    .p_len_nbits(4), .p_bubble_en(1)
  ) u_dut (
    .clk(clk), .reset(reset), .dest(dest), .len(len), .in_val(in_val),
    .in_rdy(in_rdy), .num_free_west(num_free_west), .num_free_east(num_free_east),
    .reqs(reqs), .grants(grants), .busy(busy), .flits_left(flits_left)
  );

  plab4_net_router_input_wormhole_ctrl #(
    .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2),
    .p_len_nbits(4), .p_bubble_en(0)
  ) u_dut_nb (
    .clk(clk), .reset(reset), .dest(dest), .len(len), .in_val(in_val),
    .in_rdy(nb_in_rdy), .num_free_west(num_free_west), .num_free_east(num_free_east),
    .reqs(nb_reqs), .grants(grants), .busy(nb_busy), .flits_left(nb_flits_left)
  );

  task automatic drive(input logic v, input logic [2:0] d, input logic [3:0] l,
                       input logic [1:0] fw, input logic [1:0] fe, input logic [2:0] g);
    in_val = v; dest = d; len = l;
    num_free_west = fw; num_free_east = fe; grants = g;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 3'd2, 4'd0, 2'd3, 2'd3, 3'b010);
    checks++; if (reqs !== 3'b000) begin failures++; $display("FAIL reset_reqs got=%b exp=000", reqs); end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy); end
    tick();
    checks++; if (busy !== 1'b0 || flits_left !== 4'd0) begin failures++; $display("FAIL reset_state got busy=%b flits=%0d exp busy=0 flits=0", busy, flits_left); end
    reset = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 2'd0, 2'd0, 3'b000);
    tick();
  endtask

  task automatic test_term();
    drive(1'b1, 3'd2, 4'd0, 2'd0, 2'd0, 3'b010);
    checks++; if (reqs !== 3'b010) begin failures++; $display("FAIL term_reqs got=%b exp=010", reqs); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL term_in_rdy got=%b exp=1", in_rdy); end
    tick();
    checks++; if (busy !== 1'b0 || flits_left !== 4'd0) begin failures++; $display("FAIL term_after got busy=%b flits=%0d exp busy=0 flits=0", busy, flits_left); end
    drive(1'b0, 3'd0, 4'd0, 2'd0, 2'd0, 3'b000);
  endtask

  task automatic test_bubble();
    drive(1'b1, 3'd5, 4'd0, 2'd1, 2'd3, 3'b100);
    checks++; if (reqs !== 3'b000 || in_rdy !== 1'b0) begin failures++; $display("FAIL bubble_block got reqs=%b rdy=%b exp reqs=000 rdy=0", reqs, in_rdy); end
    checks++; if (nb_reqs !== 3'b100 || nb_in_rdy !== 1'b1) begin failures++; $display("FAIL nobubble_pass got reqs=%b rdy=%b exp reqs=100 rdy=1", nb_reqs, nb_in_rdy); end
    tick();
    drive(1'b1, 3'd5, 4'd0, 2'd2, 2'd3, 3'b100);
    checks++; if (reqs !== 3'b100 || in_rdy !== 1'b1) begin failures++; $display("FAIL bubble_pass got reqs=%b rdy=%b exp reqs=100 rdy=1", reqs, in_rdy); end
    drive(1'b1, 3'd5, 4'd0, 2'd2, 2'd3, 3'b011);
    checks++; if (reqs !== 3'b100 || in_rdy !== 1'b0) begin failures++; $display("FAIL stray_grant got reqs=%b rdy=%b exp reqs=100 rdy=0", reqs, in_rdy); end
    drive(1'b1, 3'd1, 4'd0, 2'd3, 2'd1, 3'b001);
    checks++; if (reqs !== 3'b000 || nb_reqs !== 3'b001) begin failures++; $display("FAIL prev_bubble got reqs=%b nb=%b exp reqs=000 nb=001", reqs, nb_reqs); end
    drive(1'b0, 3'd0, 4'd0, 2'd0, 2'd0, 3'b000);
    tick();
  endtask

  task automatic test_prev_packet();
    drive(1'b1, 3'd7, 4'd3, 2'd0, 2'd2, 3'b001);
    checks++; if (reqs !== 3'b001 || in_rdy !== 1'b1) begin failures++; $display("FAIL prev_head got reqs=%b rdy=%b exp reqs=001 rdy=1", reqs, in_rdy); end
    tick();
    checks++; if (busy !== 1'b1 || flits_left !== 4'd3) begin failures++; $display("FAIL prev_lock got busy=%b flits=%0d exp busy=1 flits=3", busy, flits_left); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd2, 4'd0, 2'd0, 2'd1, 3'b001);
      checks++; if (reqs !== 3'b001 || in_rdy !== 1'b1) begin failures++; $display("FAIL prev_body%0d got reqs=%b rdy=%b exp reqs=001 rdy=1", i, reqs, in_rdy); end
      tick();
      checks++; if (flits_left !== 4'(2 - i)) begin failures++; $display("FAIL prev_count%0d got=%0d exp=%0d", i, flits_left, 2 - i); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prev_done got busy=%b exp=0", busy); end
    drive(1'b0, 3'd0, 4'd0, 2'd0, 2'd0, 3'b000);
  endtask

  task automatic test_tie();
    drive(1'b1, 3'd6, 4'd0, 2'd2, 2'd3, 3'b000);
    checks++; if (reqs !== 3'b100) begin failures++; $display("FAIL tie_next got=%b exp=100", reqs); end
    drive(1'b1, 3'd6, 4'd0, 2'd1, 2'd3, 3'b000);
    checks++; if (reqs !== 3'b000) begin failures++; $display("FAIL tie_bubble got=%b exp=000", reqs); end
    checks++; if (nb_reqs !== 3'b100) begin failures++; $display("FAIL tie_nobubble got=%b exp=100", nb_reqs); end
    drive(1'b0, 3'd0, 4'd0, 2'd0, 2'd0, 3'b000);
    tick();
  endtask

  task automatic test_stall_back_to_back();
    drive(1'b1, 3'd3, 4'd2, 2'd3, 2'd0, 3'b100);
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL stall_head got rdy=%b exp=1", in_rdy); end
    tick();
    checks++; if (busy !== 1'b1 || flits_left !== 4'd2) begin failures++; $display("FAIL stall_lock got busy=%b flits=%0d exp busy=1 flits=2", busy, flits_left); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 3'd3, 4'd0, 2'd3, 2'd0, 3'b100);
      checks++; if (reqs !== 3'b000) begin failures++; $display("FAIL stall_idle%0d got reqs=%b exp=000", i, reqs); end
      tick();
      checks++; if (flits_left !== 4'd2 || busy !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got busy=%b flits=%0d exp busy=1 flits=2", i, busy, flits_left); end
    end
    drive(1'b1, 3'd3, 4'd0, 2'd0, 2'd3, 3'b100);
    checks++; if (reqs !== 3'b000) begin failures++; $display("FAIL body_nocredit got=%b exp=000", reqs); end
    tick();
    drive(1'b1, 3'd0, 4'd0, 2'd1, 2'd0, 3'b111);
    checks++; if (in_rdy !== 1'b1 || reqs !== 3'b100) begin failures++; $display("FAIL body_grant_all got reqs=%b rdy=%b exp reqs=100 rdy=1", reqs, in_rdy); end
    tick();
    checks++; if (flits_left !== 4'd1) begin failures++; $display("FAIL body_dec got=%0d exp=1", flits_left); end
    drive(1'b1, 3'd0, 4'd0, 2'd1, 2'd0, 3'b100);
    tick();
    checks++; if (busy !== 1'b0 || flits_left !== 4'd0) begin failures++; $display("FAIL body_last got busy=%b flits=%0d exp busy=0 flits=0", busy, flits_left); end
    drive(1'b1, 3'd2, 4'd0, 2'd0, 2'd0, 3'b010);
    checks++; if (reqs !== 3'b010 || in_rdy !== 1'b1) begin failures++; $display("FAIL b2b_head got reqs=%b rdy=%b exp reqs=010 rdy=1", reqs, in_rdy); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_after got busy=%b exp=0", busy); end
    drive(1'b0, 3'd0, 4'd0, 2'd0, 2'd0, 3'b000);
  endtask

  task automatic test_max_len();
    drive(1'b1, 3'd2, 4'd15, 2'd0, 2'd0, 3'b010);
    tick();
    checks++; if (busy !== 1'b1 || flits_left !== 4'd15) begin failures++; $display("FAIL maxlen_lock got busy=%b flits=%0d exp busy=1 flits=15", busy, flits_left); end
    for (int i = 0; i < 14; i++) tick();
    checks++; if (busy !== 1'b1 || flits_left !== 4'd1) begin failures++; $display("FAIL maxlen_near got busy=%b flits=%0d exp busy=1 flits=1", busy, flits_left); end
    tick();
    checks++; if (busy !== 1'b0 || flits_left !== 4'd0) begin failures++; $display("FAIL maxlen_done got busy=%b flits=%0d exp busy=0 flits=0", busy, flits_left); end
    drive(1'b0, 3'd0, 4'd0, 2'd0, 2'd0, 3'b000);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd2, 4'd3, 2'd0, 2'd0, 3'b010);
    tick();
    tick();
    checks++; if (busy !== 1'b1 || flits_left !== 4'd2) begin failures++; $display("FAIL midrst_setup got busy=%b flits=%0d exp busy=1 flits=2", busy, flits_left); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || flits_left !== 4'd0) begin failures++; $display("FAIL midrst_async got busy=%b flits=%0d exp busy=0 flits=0", busy, flits_left); end
    checks++; if (reqs !== 3'b000 || in_rdy !== 1'b0) begin failures++; $display("FAIL midrst_reqs got reqs=%b rdy=%b exp reqs=000 rdy=0", reqs, in_rdy); end
    #1;
    reset = 1'b0;
    drive(1'b1, 3'd2, 4'd0, 2'd0, 2'd0, 3'b010);
    checks++; if (reqs !== 3'b010 || in_rdy !== 1'b1) begin failures++; $display("FAIL midrst_head got reqs=%b rdy=%b exp reqs=010 rdy=1", reqs, in_rdy); end
    tick();
    checks++; if (busy !== 1'b0 || flits_left !== 4'd0) begin failures++; $display("FAIL midrst_after got busy=%b flits=%0d exp busy=0 flits=0", busy, flits_left); end
    drive(1'b0, 3'd0, 4'd0, 2'd0, 2'd0, 3'b000);
  endtask

  initial begin
    reset = 1'b1;
    in_val = 1'b0; dest = '0; len = '0;
    num_free_west = '0; num_free_east = '0; grants = '0;
    #2;
    test_reset();
    test_term();
    test_bubble();
    test_prev_packet();
    test_tie();
    test_stall_back_to_back();
    test_max_len();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
